// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ready;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: turns load/store requests into aligned 64-bit bus
// transactions and returns size-adjusted, extended load data to write-back.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    output logic [63:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        misaligned,
    output logic        bus_error,
    load_store_unit_if.master mem
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;

    logic        op;
    logic        in_misaligned;
    logic [2:0]  off;
    logic [63:0] shifted;

    assign op  = MemRead | MemWrite;
    assign off = addr_q[2:0];

    always_comb begin
        unique case (funct3[1:0])
            2'b01:   in_misaligned = address[0];
            2'b10:   in_misaligned = |address[1:0];
            2'b11:   in_misaligned = |address[2:0];
            default: in_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        berr_d  = berr_q;

        unique case (state_q)
            S_IDLE: begin
                if (op) begin
                    addr_d  = address;
                    f3_d    = funct3;
                    we_d    = MemWrite;
                    wdata_d = write_data;
                    rdata_d = '0;
                    cnt_d   = '0;
                    mis_d   = 1'b0;
                    berr_d  = 1'b0;
                    // Stores have no unsigned variants, so funct3[2] is illegal for them.
                    if (funct3 == 3'b111 || (MemWrite && funct3[2])) begin
                        berr_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (in_misaligned) begin
                        mis_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_ready) begin
                    rdata_d = mem.mem_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    berr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                mis_d   = 1'b0;
                berr_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_wstrb = '0;
        if (state_q == S_REQ) begin
            mem.mem_req   = 1'b1;
            mem.mem_we    = we_q;
            mem.mem_addr  = {addr_q[63:3], 3'b000};
            mem.mem_wdata = wdata_q << {off, 3'b000};
            if (we_q) begin
                unique case (f3_q[1:0])
                    2'b00:   mem.mem_wstrb = 8'h01 << off;
                    2'b01:   mem.mem_wstrb = 8'h03 << off;
                    2'b10:   mem.mem_wstrb = 8'h0F << off;
                    default: mem.mem_wstrb = 8'hFF;
                endcase
            end
        end
    end

    assign stall      = (state_q == S_REQ) || (state_q == S_IDLE && op);
    assign done       = (state_q == S_DONE);
    assign misaligned = done & mis_q;
    assign bus_error  = done & berr_q;
    assign shifted    = rdata_q >> {off, 3'b000};

    always_comb begin
        read_data = '0;
        if (done && !we_q && !mis_q && !berr_q) begin
            unique case (f3_q)
                3'b000:  read_data = {{56{shifted[7]}}, shifted[7:0]};
                3'b001:  read_data = {{48{shifted[15]}}, shifted[15:0]};
                3'b010:  read_data = {{32{shifted[31]}}, shifted[31:0]};
                3'b011:  read_data = shifted;
                3'b100:  read_data = {56'd0, shifted[7:0]};
                3'b101:  read_data = {48'd0, shifted[15:0]};
                3'b110:  read_data = {32'd0, shifted[31:0]};
                default: read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random accesses checked
// against an arithmetic model of sizes, offsets and extension rules.
module tb_load_store_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [63:0] address, write_data;
    logic [63:0] read_data;
    logic        stall, done, misaligned, bus_error;

    int tests = 0;
    int fails = 0;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .done       (done),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction: op presented, REQ cycles with ready after `delay`
    // wait cycles (or timeout), then the single DONE cycle.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input logic [63:0] rdat, input int unsigned delay);
        int unsigned nbytes, off;
        logic        store, illegal, misal, timed_out;
        logic [63:0] mask, v, exp_rd;
        logic [7:0]  exp_strb;

        store   = wr;
        nbytes  = 1 << f3[1:0];
        off     = int'(addr % 8);
        illegal = (f3 == 3'd7) || (wr && f3 >= 3'd4);
        misal   = !illegal && ((addr % nbytes) != 0);
        exp_strb = store ? 8'(((1 << nbytes) - 1) << off) : 8'h00;
        timed_out = 1'b0;

        @(negedge clk);
        MemRead = rd; MemWrite = wr; funct3 = f3; address = addr; write_data = wd;
        bus.mem_ready = 1'b0; bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        chk("op_stall", 64'(stall), 64'd1);
        chk("op_req", 64'(bus.mem_req), 64'd0);
        chk("op_done", 64'(done), 64'd0);

        if (!illegal && !misal) begin
            for (int unsigned i = 0; i < TMO; i++) begin
                @(negedge clk);
                bus.mem_ready = (i == delay);
                bus.mem_rdata = (i == delay) ? rdat : {$urandom, $urandom};
                #1;
                chk("req_req", 64'(bus.mem_req), 64'd1);
                chk("req_we", 64'(bus.mem_we), 64'(store));
                chk("req_addr", bus.mem_addr, addr & ~64'd7);
                chk("req_wdata", bus.mem_wdata, wd << (8 * off));
                chk("req_wstrb", 64'(bus.mem_wstrb), 64'(exp_strb));
                chk("req_stall", 64'(stall), 64'd1);
                chk("req_done", 64'(done), 64'd0);
                if (i == delay) break;
                if (i == TMO - 1) timed_out = 1'b1;
            end
        end

        exp_rd = 64'd0;
        if (!store && !illegal && !misal && !timed_out) begin
            v = rdat >> (8 * off);
            if (nbytes < 8) begin
                mask = (64'd1 << (8 * nbytes)) - 64'd1;
                v = v & mask;
                if (f3 < 3'd4 && v[8 * nbytes - 1]) v = v | ~mask;
            end
            exp_rd = v;
        end

        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        chk("dn_done", 64'(done), 64'd1);
        chk("dn_stall", 64'(stall), 64'd0);
        chk("dn_req", 64'(bus.mem_req), 64'd0);
        chk("dn_misal", 64'(misaligned), 64'(misal));
        chk("dn_berr", 64'(bus_error), 64'(illegal || timed_out));
        chk("dn_rdata", read_data, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rd, wr;
        logic [2:0]  f3;
        logic [63:0] a;
        int unsigned nb, r, dly;

        reset = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; funct3 = '0; address = '0; write_data = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_req", 64'(bus.mem_req), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rdata", read_data, 64'd0);
        chk("rst_flags", 64'({misaligned, bus_error}), 64'd0);

        run_op(1, 0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0);  // LB
        chk("lb_value", read_data, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(1, 0, 3'b100, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0);  // LBU
        chk("lbu_value", read_data, 64'h80);
        run_op(0, 1, 3'b001, 64'h2006, 64'h1234, 64'h0, 3);                 // SH
        run_op(1, 0, 3'b010, 64'h3002, 64'h0, 64'h0, 0);                    // LW misaligned
        run_op(1, 0, 3'b011, 64'h5000, 64'h0, 64'h0, 1000);                 // LD timeout
        run_op(1, 0, 3'b111, 64'h6000, 64'h0, 64'h0, 0);                    // illegal
        run_op(1, 1, 3'b011, 64'h0, 64'hA5A5_5A5A_0123_4567, 64'h0, 0);     // both -> SD
        run_op(0, 1, 3'b100, 64'h7000, 64'h0, 64'h0, 0);                    // store with unsigned code

        // Reset during the second REQ cycle.
        @(negedge clk);
        MemRead = 1'b1; funct3 = 3'b011; address = 64'h5008;
        @(negedge clk);
        #1;
        chk("mr_req1", 64'(bus.mem_req), 64'd1);
        @(negedge clk);
        reset = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_req", 64'(bus.mem_req), 64'd0);
        chk("mr_stall", 64'(stall), 64'd0);
        chk("mr_done", 64'(done), 64'd0);
        run_op(1, 0, 3'b110, 64'h4, 64'h0, 64'hF000_0000_0000_0000, 0);     // LWU
        chk("lwu_value", read_data, 64'h0000_0000_F000_0000);

        for (int n = 0; n < 40; n++) begin
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            f3 = 3'($urandom_range(0, 7));
            if (wr && $urandom_range(0, 3) != 0) f3[2] = 1'b0;
            if (f3 == 3'd7 && $urandom_range(0, 2) != 0) f3 = 3'd3;
            a = {$urandom, $urandom};
            nb = 1 << f3[1:0];
            if ($urandom_range(0, 2) != 0) a = a & ~(64'(nb) - 64'd1);
            r = $urandom_range(0, 9);
            dly = (r == 9) ? 40 : r % 4;
            run_op(rd, wr, f3, a, {$urandom, $urandom}, {$urandom, $urandom}, dly);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage that sits between the execute-stage ALU result and the write-back mux.
- Turns MemRead/MemWrite plus funct3 and the ALU address into aligned 64-bit data-memory transactions, using a req/ready handshake with byte strobes.
- Returns size-adjusted, sign- or zero-extended load data to write-back.
- Holds the processor with `stall` until the access completes, times out, or is rejected as misaligned or illegal.

Parameters:
- TIMEOUT, 16, max cycles in REQ waiting for mem_ready before a bus error is flagged (legal range 1..255).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- MemRead  in  1  load request from control unit
- MemWrite  in  1  store request from control unit
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- address  in  64  byte address (ALU result)
- write_data  in  64  store data (rs2 value), taken from its least-significant bytes
- read_data  out  64  extended load data, valid when done=1
- stall  out  1  hold PC and upstream stages
- done  out  1  one-cycle completion pulse
- misaligned  out  1  with done: access not naturally aligned; no memory request was made
- bus_error  out  1  with done: timeout or illegal funct3
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = store
- mem_addr  out  64  address with bits [2:0] = 0
- mem_wdata  out  64  lane-shifted store data
- mem_wstrb  out  8  byte-enable lanes
- mem_ready  in  1  memory accepted/completed the request this cycle
- mem_rdata  in  64  read doubleword, valid when mem_ready=1

Behaviour:
- Reset values: state IDLE; all outputs and internal registers 0.
  - Reset wins over every other condition, including mid-REQ; mem_req is 0 after the reset edge.
- State IDLE:
  - op = MemRead | MemWrite. If both are set, the access is a store.
  - stall = op (combinational) in IDLE.
  - On an op, latch address, funct3, type and write_data.
  - If funct3 = 111, or a store uses funct3 bit 2 = 1: go to DONE with bus_error.
  - Else if offset = address[2:0] is not aligned (H: off[0]≠0; W: off[1:0]≠0; D: off≠0): go to DONE with misaligned.
  - Otherwise go to REQ.
- State REQ:
  - mem_req=1, mem_we=store, mem_addr={addr[63:3],3'b000}.
  - mem_wdata = wdata << (8*off).
  - mem_wstrb = B 8'h01<<off, H 8'h03<<off, W 8'h0F<<off, D 8'hFF (0 for loads).
  - All memory-side outputs stay stable until mem_ready.
  - stall=1.
  - A wait counter clears on entry and increments each cycle mem_ready=0.
  - mem_ready=1 → capture mem_rdata and go to DONE; mem_req drops on the next cycle.
  - Counter reaches TIMEOUT-1 with no ready → DONE with bus_error=1; read_data=0.
- State DONE, held for exactly one cycle:
  - done=1, stall=0, mem_req=0.
  - read_data = (rdata >> 8*off), extended per funct3. B/H/W sign-extend bit 7/15/31; BU/HU/WU zero-extend; D passes through.
  - read_data = 0 for stores and errors.
  - Then return to IDLE.
  - misaligned and bus_error are valid only with done, and are 0 otherwise.
- Latency:
  - Aligned access with mem_ready in the first REQ cycle: done is high 2 cycles after the op is presented.
  - Error paths: done is high 1 cycle after the op is presented.
- Inputs are ignored outside IDLE. Upstream holds them stable while stall=1.
- A back-to-back op presented in the cycle after DONE is accepted normally.
- An op held high through DONE starts a new transaction.

Test Plan:
- LB address 0x1003, mem_rdata 0x0000_0000_8000_0000 with ready in the 1st REQ cycle → mem_addr 0x1000; done at cycle +2; read_data 0xFFFF_FFFF_FFFF_FF80. LBU on the same data → 0x80.
- SH address 0x2006, write_data 0x1234 → mem_wstrb 0xC0, mem_wdata 0x1234_0000_0000_0000, mem_we=1; mem_req is held for 3 cycles of ready=0, then ready → done, read_data=0.
- LW address 0x3002 → no mem_req; done and misaligned at cycle +1; stall=1 in the op cycle only.
- LD with mem_ready stuck at 0, TIMEOUT=16 → mem_req high 16 cycles; then done+bus_error, read_data=0; state returns to IDLE.
- funct3=111 with MemRead → done+bus_error at +1, no mem_req. MemRead and MemWrite both set with SD at 0x0 → store with wstrb 0xFF.
- reset asserted in the 2nd REQ cycle → mem_req=0, stall=0, done=0 after the edge. A new LWU at 0x4 with rdata 0xF000_0000_0000_0000 → read_data 0x0000_0000_F000_0000.
